// File: rtl/multicore_collector.sv
// Serialises per-core results through edge-detected capture holds, a round-robin arbiter and an output FIFO.
// Optional COLLECT_STATS_EN adds a saturating drop_cnt output counting results lost to overrun.
module multicore_collector #(
  parameter int N_CORES = 21,
  parameter int DW      = 28,
  parameter int DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CORES*DW-1:0] in_data,
  input  logic [N_CORES*4-1:0]  in_en,
  output logic [DW-1:0]         out_data,
  output logic [4:0]            out_core,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CORES-1:0]    overrun,
  output logic                  fifo_full
`ifdef COLLECT_STATS_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + DW;

  logic [N_CORES*4-1:0] en_prev_q, en_prev_d;
  logic [DW-1:0]        hold_q [N_CORES];
  logic [DW-1:0]        hold_d [N_CORES];
  logic [N_CORES-1:0]   hold_v_q, hold_v_d;
  logic [N_CORES-1:0]   overrun_q, overrun_d;
  logic [4:0]           ptr_q, ptr_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        mem_d [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [5:0]           ovr_num;

  logic          pop, full, push_ok, push, grant_vld;
  logic [4:0]    grant_idx;
  logic [DW-1:0] grant_dat;

  function automatic int rr_idx(input logic [4:0] p, input int i);
    int s;
    s = int'(p) + i;
    return (s >= N_CORES) ? s - N_CORES : s;
  endfunction

  always_comb begin
    pop       = (cnt_q != '0) && out_ready;
    full      = (cnt_q == (AW+1)'(DEPTH));
    push_ok   = !full || pop;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_dat = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!grant_vld && hold_v_q[rr_idx(ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = 5'(rr_idx(ptr_q, i));
        grant_dat = hold_q[rr_idx(ptr_q, i)];
      end
    end
    push = grant_vld && push_ok;
  end

  // A hold being drained this cycle may take a new value; otherwise a second edge is dropped.
  always_comb begin
    en_prev_d = in_en;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    overrun_d = overrun_q;
    ovr_num   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (push && grant_idx == 5'(k)) hold_v_d[k] = 1'b0;
      if (in_en[k*4 +: 4] == 4'd1 && en_prev_q[k*4 +: 4] != 4'd1) begin
        if (!hold_v_q[k] || (push && grant_idx == 5'(k))) begin
          hold_d[k]   = in_data[k*DW +: DW];
          hold_v_d[k] = 1'b1;
        end else begin
          overrun_d[k] = 1'b1;
          ovr_num      = ovr_num + 6'd1;
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ptr_d = ptr_q;
    if (push) begin
      mem_d[wr_q] = {grant_idx, grant_dat};
      wr_d        = wr_q + AW'(1);
      ptr_d       = (grant_idx == 5'(N_CORES-1)) ? 5'd0 : grant_idx + 5'd1;
    end
    if (pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_prev_q <= '0;
      hold_q    <= '{default: '0};
      hold_v_q  <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      en_prev_q <= en_prev_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign {out_core, out_data} = mem_q[rd_q];
  assign out_valid            = (cnt_q != '0);
  assign fifo_full            = full;
  assign overrun              = overrun_q;

`ifdef COLLECT_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(ovr_num);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule
